// File: rtl/alu_md_pkg.sv
// Shared encodings for the EX-stage ALU / multiply-divide unit.
package alu_md_pkg;

  // Decoded operation codes, also exported on aluControl
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_BR   = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;
  localparam logic [3:0] ALU_MULH = 4'b1101;
  localparam logic [3:0] ALU_DIV  = 4'b1110;
  localparam logic [3:0] ALU_REM  = 4'b1111;

  // aluOp encodings from the main decoder
  localparam logic [1:0] AOP_MEM = 2'b00;
  localparam logic [1:0] AOP_BIT = 2'b01;
  localparam logic [1:0] AOP_BR  = 2'b10;
  localparam logic [1:0] AOP_UPI = 2'b11;

  // Instruction opcode / funct7 constants
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] M_EXT = 7'b0000001;

  // Handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/md_iter_core.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// mode 0: {hi,lo} = signed-fixed product. mode 1: hi = remainder, lo = quotient.
// last is high during the cycle whose clock edge performs the final iteration.
module md_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic            a_signed,
  input  logic            b_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            running;
  logic [CW-1:0]   cnt;
  logic            mode_q;
  logic            neg_q;
  logic            rneg_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // Operand magnitudes and per-step arithmetic
  always_comb begin
    a_neg     = a_signed & a[XLEN-1];
    b_neg     = b_signed & b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    last      = running && (cnt == CW'(XLEN - 1));
  end

  // Iteration registers: load on start, then XLEN shift steps
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      mode_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mode_q  <= mode;
      neg_q   <= a_neg ^ b_neg;
      rneg_q  <= mode & a_neg;
      hi_q    <= '0;
      lo_q    <= mode ? a_mag : b_mag;
      b_q     <= mode ? b_mag : a_mag;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        running <= 1'b0;
      end
      if (!mode_q) begin
        {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
        hi_q <= div_diff[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_q <= div_shift[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign fixup of the magnitude results
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = rneg_q ? -hi_q : hi_q;
    hi       = mode_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
    lo       = mode_q ? quo_fix : prod_fix[XLEN-1:0];
  end

endmodule

// File: rtl/alu_md_exec_unit.sv
// EX-stage ALU with RV32M multiply/divide, valid/ready handshakes on both sides.
module alu_md_exec_unit
  import alu_md_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inValid,
  output logic            inReady,
  input  logic [1:0]      aluOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      instrnOpcode,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result,
  output logic [3:0]      aluControl
);

  localparam int SHW = $clog2(XLEN);

  state_t state;
  state_t state_n;

  logic [3:0]      dec_op;
  logic            m_sel;
  logic [SHW-1:0]  sh;
  logic            taken;
  logic [XLEN-1:0] alu_res;

  logic            is_mul;
  logic            is_div;
  logic            a_sgn;
  logic            b_sgn;
  logic            div_zero;
  logic            div_ovf;
  logic            bypass;
  logic [XLEN-1:0] byp_res;
  logic            iterate;
  logic            sel_hi;
  logic            accept;

  logic [XLEN-1:0] res_q;
  logic [3:0]      ctl_q;
  logic            use_core_q;
  logic            sel_hi_q;

  logic            core_last;
  logic [XLEN-1:0] core_hi;
  logic [XLEN-1:0] core_lo;

  // Operation decode from aluOp / funct3 / funct7 / opcode
  always_comb begin
    dec_op = ALU_ADD;
    m_sel  = (ENABLE_M != 0) && (instrnOpcode == OP_R) && (funct7 == M_EXT);
    case (aluOp)
      AOP_MEM: dec_op = ALU_ADD;
      AOP_BIT: begin
        if (m_sel) begin
          case (funct3)
            3'b000:                 dec_op = ALU_MUL;
            3'b001, 3'b010, 3'b011: dec_op = ALU_MULH;
            3'b100, 3'b101:         dec_op = ALU_DIV;
            default:                dec_op = ALU_REM;
          endcase
        end else if ((instrnOpcode == OP_R) && funct7[5] && (funct3 == 3'b000)) begin
          dec_op = ALU_SUB;
        end else if (funct7[5] && (funct3 == 3'b101) &&
                     ((instrnOpcode == OP_R) || (instrnOpcode == OP_I))) begin
          dec_op = ALU_SRA;
        end else begin
          case (funct3)
            3'b000:  dec_op = ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end
      end
      AOP_BR:  dec_op = ALU_BR;
      default: dec_op = ALU_LUI;
    endcase
  end

  // Single-cycle datapath and branch condition
  always_comb begin
    sh = operandB[SHW-1:0];
    case (funct3)
      3'b000:  taken = (operandA == operandB);
      3'b001:  taken = (operandA != operandB);
      3'b100:  taken = ($signed(operandA) <  $signed(operandB));
      3'b101:  taken = ($signed(operandA) >= $signed(operandB));
      3'b110:  taken = (operandA <  operandB);
      3'b111:  taken = (operandA >= operandB);
      default: taken = 1'b0;
    endcase
    case (dec_op)
      ALU_ADD:  alu_res = operandA + operandB;
      ALU_SUB:  alu_res = operandA - operandB;
      ALU_SLL:  alu_res = operandA << sh;
      ALU_XOR:  alu_res = operandA ^ operandB;
      ALU_SRL:  alu_res = operandA >> sh;
      ALU_SRA:  alu_res = $unsigned($signed(operandA) >>> sh);
      ALU_OR:   alu_res = operandA | operandB;
      ALU_AND:  alu_res = operandA & operandB;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(operandA) < $signed(operandB)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, operandA < operandB};
      ALU_BR:   alu_res = {{(XLEN-1){1'b0}}, taken};
      ALU_LUI:  alu_res = operandB;
      default:  alu_res = '0;
    endcase
  end

  // M-extension signedness and divide corner-case bypass
  always_comb begin
    is_mul   = (dec_op == ALU_MUL) || (dec_op == ALU_MULH);
    is_div   = (dec_op == ALU_DIV) || (dec_op == ALU_REM);
    a_sgn    = ((dec_op == ALU_MULH) && (funct3 != 3'b011)) || (is_div && !funct3[0]);
    b_sgn    = ((dec_op == ALU_MULH) && (funct3 == 3'b001)) || (is_div && !funct3[0]);
    div_zero = (operandB == '0);
    div_ovf  = !funct3[0] && (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (operandB == '1);
    bypass   = is_div && (div_zero || div_ovf);
    if (dec_op == ALU_DIV) begin
      byp_res = div_zero ? '1 : operandA;
    end else begin
      byp_res = div_zero ? operandA : '0;
    end
    iterate = is_mul || (is_div && !bypass);
    sel_hi  = (dec_op == ALU_MULH) || (dec_op == ALU_REM);
    accept  = inValid && inReady;
  end

  md_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && iterate),
    .mode     (is_div),
    .a_signed (a_sgn),
    .b_signed (b_sgn),
    .a        (operandA),
    .b        (operandB),
    .last     (core_last),
    .hi       (core_hi),
    .lo       (core_lo)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!iterate)    state_n = ST_DONE;
          else if (is_mul) state_n = ST_MUL;
          else             state_n = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (core_last) state_n = ST_DONE;
      end
      default: begin
        if (outReady) state_n = ST_IDLE;
      end
    endcase
  end

  // Capture decode and single-cycle / bypass result on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q      <= '0;
      ctl_q      <= '0;
      use_core_q <= 1'b0;
      sel_hi_q   <= 1'b0;
    end else if (accept) begin
      res_q      <= bypass ? byp_res : alu_res;
      ctl_q      <= dec_op;
      use_core_q <= iterate;
      sel_hi_q   <= sel_hi;
    end
  end

  // Iterative results are read straight from the core, which holds them until
  // the next start; this lets DONE coincide with the final iteration edge.
  always_comb begin
    inReady    = (state == ST_IDLE) && !reset;
    outValid   = (state == ST_DONE);
    result     = use_core_q ? (sel_hi_q ? core_hi : core_lo) : res_q;
    aluControl = ctl_q;
  end

endmodule

// File: tb/tb_alu_md_exec_unit.sv
// Self-checking bench: vector table through a scoreboard, random M-extension
// ops against a behavioural model, and hand sequences for stall/reset cases.
module tb_alu_md_exec_unit;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] B_OP  = 7'b1100011;
  localparam logic [6:0] L_OP  = 7'b0000011;
  localparam logic [6:0] U_OP  = 7'b0110111;
  localparam logic [6:0] F7M   = 7'b0000001;
  localparam logic [6:0] F7A   = 7'b0100000;
  localparam logic [6:0] F70   = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  iv;
  logic        outReady;
  logic [1:0]  aluOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [6:0]  opc;
  logic [31:0] opA;
  logic [31:0] opB;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [31:0] res0, res2;
  logic [15:0] res1;
  logic [3:0]  ctl0, ctl1, ctl2;

  logic [2:0]  ir_v;
  logic [2:0]  ov_v;
  logic [31:0] res_v [3];
  logic [3:0]  ctl_v [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_md_exec_unit #(.XLEN(32), .ENABLE_M(1)) u_main (
    .clk(clk), .reset(reset), .inValid(iv[0]), .inReady(ir0),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .instrnOpcode(opc),
    .operandA(opA), .operandB(opB), .outValid(ov0), .outReady(outReady),
    .result(res0), .aluControl(ctl0)
  );

  alu_md_exec_unit #(.XLEN(16), .ENABLE_M(1)) u_x16 (
    .clk(clk), .reset(reset), .inValid(iv[1]), .inReady(ir1),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .instrnOpcode(opc),
    .operandA(opA[15:0]), .operandB(opB[15:0]), .outValid(ov1), .outReady(outReady),
    .result(res1), .aluControl(ctl1)
  );

  alu_md_exec_unit #(.XLEN(32), .ENABLE_M(0)) u_nom (
    .clk(clk), .reset(reset), .inValid(iv[2]), .inReady(ir2),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .instrnOpcode(opc),
    .operandA(opA), .operandB(opB), .outValid(ov2), .outReady(outReady),
    .result(res2), .aluControl(ctl2)
  );

  always_comb begin
    ir_v     = {ir2, ir1, ir0};
    ov_v     = {ov2, ov1, ov0};
    res_v[0] = res0;
    res_v[1] = {16'h0, res1};
    res_v[2] = res2;
    ctl_v[0] = ctl0;
    ctl_v[1] = ctl1;
    ctl_v[2] = ctl2;
  end

  typedef struct {
    int          dut;
    logic [1:0]  aop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  ctl;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    int          dut;
    logic [31:0] res;
    logic [3:0]  ctl;
    int          lat;
    string       name;
  } exp_t;

  exp_t scb[$];
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int dut, input logic [1:0] aop, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [6:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic [3:0] ctl,
                              input int lat, input string name);
    vec_t v;
    v.dut = dut; v.aop = aop; v.f3 = f3; v.f7 = f7; v.op = op;
    v.a = a; v.b = b; v.res = res; v.ctl = ctl; v.lat = lat; v.name = name;
    return v;
  endfunction

  // Behavioural RV32M reference
  function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sbv, ub;
    logic [63:0] za, zb, p;
    logic        ovf;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ub  = longint'({32'h0, b});
    za  = {32'h0, a};
    zb  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = za * zb;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sbv; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sbv; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input vec_t v);
    exp_t e;
    exp_t g;
    int   lat;
    bit   seen;
    e.dut = v.dut; e.res = v.res; e.ctl = v.ctl; e.lat = v.lat; e.name = v.name;
    @(negedge clk);
    check({v.name, " inReady idle"}, 32'(ir_v[v.dut]), 32'd1);
    aluOp = v.aop; funct3 = v.f3; funct7 = v.f7; opc = v.op; opA = v.a; opB = v.b;
    iv[v.dut] = 1'b1;
    scb.push_back(e);
    @(posedge clk);
    #1 iv = '0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (ov_v[v.dut]) seen = 1'b1;
      else check({v.name, " inReady busy"}, 32'(ir_v[v.dut]), 32'd0);
    end
    if (scb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard: got empty queue expected entry", v.name);
    end else begin
      g = scb.pop_front();
      if (!seen) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout: got no outValid in %0d cycles expected %0d", g.name, lat, g.lat);
      end else begin
        check({g.name, " result"}, res_v[g.dut], g.res);
        check({g.name, " aluControl"}, 32'(ctl_v[g.dut]), 32'(g.ctl));
        check({g.name, " latency"}, lat, g.lat);
        check({g.name, " inReady done"}, 32'(ir_v[g.dut]), 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    logic [31:0] a, b, r1;
    logic [2:0]  f3;
    int          lat;
    bit          spurious;

    vt.push_back(mk(0, 2'b01, 3'b000, F7A, R_OP, 32'd10, 32'd3, 32'd7, 4'h1, 1, "sub"));
    vt.push_back(mk(0, 2'b01, 3'b101, F7A, I_OP, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'h5, 1, "srai"));
    vt.push_back(mk(0, 2'b01, 3'b000, F7A, I_OP, 32'd10, 32'd3, 32'd13, 4'h0, 1, "addi_f7"));
    vt.push_back(mk(0, 2'b00, 3'b010, F70, L_OP, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'h0, 1, "mem_add_wrap"));
    vt.push_back(mk(0, 2'b01, 3'b001, F70, R_OP, 32'd1, 32'h23, 32'd8, 4'h2, 1, "sll"));
    vt.push_back(mk(0, 2'b01, 3'b101, F70, R_OP, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'h4, 1, "srl"));
    vt.push_back(mk(0, 2'b01, 3'b010, F70, R_OP, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'h8, 1, "slt"));
    vt.push_back(mk(0, 2'b01, 3'b011, F70, R_OP, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'h9, 1, "sltu"));
    vt.push_back(mk(0, 2'b01, 3'b100, F70, R_OP, 32'hF0F0, 32'hFF00, 32'h0FF0, 4'h3, 1, "xor"));
    vt.push_back(mk(0, 2'b01, 3'b110, F70, R_OP, 32'hF0F0, 32'hFF00, 32'hFFF0, 4'h6, 1, "or"));
    vt.push_back(mk(0, 2'b01, 3'b111, F70, R_OP, 32'hF0F0, 32'hFF00, 32'hF000, 4'h7, 1, "and"));
    vt.push_back(mk(0, 2'b11, 3'b000, F70, U_OP, 32'h7B, 32'h1234_5000, 32'h1234_5000, 4'hB, 1, "lui"));
    vt.push_back(mk(0, 2'b10, 3'b110, F70, B_OP, 32'd1, 32'hFFFF_FFFF, 32'd1, 4'hA, 1, "bltu"));
    vt.push_back(mk(0, 2'b10, 3'b101, F70, B_OP, 32'd1, 32'hFFFF_FFFF, 32'd1, 4'hA, 1, "bge"));
    vt.push_back(mk(0, 2'b10, 3'b000, F70, B_OP, 32'd5, 32'd5, 32'd1, 4'hA, 1, "beq"));
    vt.push_back(mk(0, 2'b10, 3'b001, F70, B_OP, 32'd5, 32'd5, 32'd0, 4'hA, 1, "bne"));
    vt.push_back(mk(0, 2'b10, 3'b010, F70, B_OP, 32'd5, 32'd5, 32'd0, 4'hA, 1, "br_f3_010"));
    vt.push_back(mk(0, 2'b10, 3'b100, F70, B_OP, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'hA, 1, "blt"));
    vt.push_back(mk(0, 2'b01, 3'b000, F7M, R_OP, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 4'hC, 33, "mul"));
    vt.push_back(mk(0, 2'b01, 3'b011, F7M, R_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'hD, 33, "mulhu"));
    vt.push_back(mk(0, 2'b01, 3'b001, F7M, R_OP, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 4'hD, 33, "mulh"));
    vt.push_back(mk(0, 2'b01, 3'b100, F7M, R_OP, 32'd7, 32'd0, 32'hFFFF_FFFF, 4'hE, 1, "div_by0"));
    vt.push_back(mk(0, 2'b01, 3'b110, F7M, R_OP, 32'd7, 32'd0, 32'd7, 4'hF, 1, "rem_by0"));
    vt.push_back(mk(0, 2'b01, 3'b100, F7M, R_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'hE, 1, "div_ovf"));
    vt.push_back(mk(0, 2'b01, 3'b110, F7M, R_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 4'hF, 1, "rem_ovf"));
    vt.push_back(mk(0, 2'b01, 3'b100, F7M, R_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4'hE, 33, "div_neg"));
    vt.push_back(mk(0, 2'b01, 3'b110, F7M, R_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'hF, 33, "rem_neg"));
    vt.push_back(mk(0, 2'b01, 3'b101, F7M, R_OP, 32'd100, 32'd7, 32'd14, 4'hE, 33, "divu"));
    vt.push_back(mk(0, 2'b01, 3'b111, F7M, R_OP, 32'd100, 32'd7, 32'd2, 4'hF, 33, "remu"));
    vt.push_back(mk(0, 2'b01, 3'b101, F7M, R_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 4'hE, 33, "divu_no_ovf"));
    vt.push_back(mk(1, 2'b01, 3'b101, F7M, R_OP, 32'hFFFF, 32'd3, 32'h5555, 4'hE, 17, "x16_divu"));
    vt.push_back(mk(1, 2'b01, 3'b000, F7M, R_OP, 32'hFFFD, 32'd7, 32'hFFEB, 4'hC, 17, "x16_mul"));
    vt.push_back(mk(2, 2'b01, 3'b000, F7M, R_OP, 32'd5, 32'd6, 32'd11, 4'h0, 1, "nom_add"));

    // Reset state
    reset = 1'b1; iv = '0; outReady = 1'b1;
    aluOp = '0; funct3 = '0; funct7 = '0; opc = '0; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset inReady", 32'(ir_v), 32'd0);
    check("reset outValid", 32'(ov_v), 32'd0);
    check("reset result", res0, 32'd0);
    check("reset aluControl", 32'(ctl0), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset inReady", 32'(ir_v), 32'h7);

    foreach (vt[i]) run_op(vt[i]);

    // Random M-extension ops against the model
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
      v = mk(0, 2'b01, f3, F7M, R_OP, a, b, md_ref(f3, a, b),
             (f3 == 0) ? 4'hC : (!f3[2] ? 4'hD : (!f3[1] ? 4'hE : 4'hF)), lat, "rand_md");
      run_op(v);
    end

    // Output stall: result held while outReady low, second request ignored
    @(negedge clk);
    aluOp = 2'b00; funct3 = 3'b000; funct7 = F70; opc = L_OP; opA = 32'd1; opB = 32'd2;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv = '0; outReady = 1'b0;
    @(negedge clk);
    check("stall first valid", 32'(ov0), 32'd1);
    r1 = res0;
    check("stall first result", r1, 32'd3);
    for (int k = 0; k < 5; k++) begin
      aluOp = 2'b01; funct3 = 3'b100; funct7 = F70; opc = R_OP; opA = 32'd6; opB = 32'd3;
      iv[0] = 1'b1;
      @(negedge clk);
      check("stall outValid", 32'(ov0), 32'd1);
      check("stall result", res0, 32'd3);
      check("stall aluControl", 32'(ctl0), 32'd0);
      check("stall inReady", 32'(ir0), 32'd0);
    end
    outReady = 1'b1;
    @(negedge clk);
    check("handshake done outValid", 32'(ov0), 32'd0);
    check("handshake done inReady", 32'(ir0), 32'd1);
    @(posedge clk);
    #1 iv = '0;
    @(negedge clk);
    check("second op valid", 32'(ov0), 32'd1);
    check("second op result", res0, 32'd5);
    check("second op aluControl", 32'(ctl0), 32'd3);

    // Reset while dividing: operation dropped, no result appears
    @(negedge clk);
    aluOp = 2'b01; funct3 = 3'b101; funct7 = F7M; opc = R_OP; opA = 32'd100; opB = 32'd7;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv = '0;
    repeat (5) @(negedge clk);
    check("mid-div inReady", 32'(ir0), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid-div reset inReady", 32'(ir0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort outValid", 32'(ov0), 32'd0);
    check("abort inReady", 32'(ir0), 32'd1);
    check("abort result", res0, 32'd0);
    spurious = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov0) spurious = 1'b1;
    end
    check("abort no spurious result", 32'(spurious), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_md_exec_unit.md
Name: alu_md_exec_unit

Overview:
- Parametrised successor to the ALU control decoder. It decodes aluOp/funct3/funct7/opcode and also executes the operation, adding the RV32M multiply/divide family.
- Single-cycle ops complete in 1 cycle. MUL*/DIV*/REM* run on an iterative datapath.
- Sits in the EX stage, with valid/ready handshakes so the hazard unit can stall ID/EX while busy.

Parameters:
XLEN, 32, operand/result width (even, >=8)
ENABLE_M, 1, 1 = decode and execute M-extension; 0 = funct7==7'b0000001 R-type treated as base ALU op

Ports:
clk  input  1  clock
reset  input  1  reset; synchronous, active-high
inValid  input  1  operation presented
inReady  output  1  unit can accept an operation this cycle
aluOp  input  2  00 memory, 01 bitwise/shift, 10 branch, 11 upper-immediate
funct3  input  3  instruction funct3
funct7  input  7  instruction funct7
instrnOpcode  input  7  instruction opcode
operandA  input  XLEN  rs1 value
operandB  input  XLEN  rs2 value or immediate
outValid  output  1  result valid
outReady  input  1  consumer accepts result
result  output  XLEN  ALU/MD result; branch ops return {0…,taken}
aluControl  output  4  registered decoded op code, for debug/trace

Behaviour:
- Reset: state IDLE; inReady=0 during reset, 1 the cycle after; outValid=0; result=0; aluControl=0; iterative registers cleared. Reset mid-operation aborts the operation and no result is produced.
- Decode op codes:
  - add 0000, sub 0001, sll 0010, xor 0011, srl 0100, sra 0101, or 0110, and 0111, slt 1000
  - sltu 1001, branch 1010, lui-pass 1011, mul 1100, mulh* 1101, div* 1110, rem* 1111
- aluOp 00: add.
- aluOp 01:
  - R-type (0110011) with funct7[5]: sub (funct3 000) or sra (funct3 101).
  - I-type (0010011) with funct7[5] and funct3 101: sra.
  - funct3 011: sltu.
  - R-type with funct7==0000001 and ENABLE_M: funct3 000 mul, 001/010/011 mulh/mulhsu/mulhu, 100/101 div/divu, 110/111 rem/remu.
  - Otherwise the base funct3 table applies.
- aluOp 10: taken per funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; other values give taken=0.
- aluOp 11: result=operandB.
- Shift amount is operandB[$clog2(XLEN)-1:0]. All arithmetic wraps modulo 2^XLEN.
- FSM IDLE/MUL/DIV/DONE:
  - IDLE: inReady=1. A transfer occurs when inValid&&inReady; operands and decode are captured.
  - Single-cycle op: IDLE→DONE, so outValid rises on the edge after acceptance (latency 1).
  - mul*: IDLE→MUL, XLEN shift-add iterations on magnitudes with sign fixup, then DONE. Latency XLEN+1.
  - div*/rem*: IDLE→DIV, XLEN restoring iterations, then DONE. Latency XLEN+1.
  - DONE: outValid=1; result and aluControl held stable until outReady. outValid&&outReady → IDLE.
  - inReady=0 in MUL, DIV and DONE: no back-to-back acceptance, one op in flight.
- Divide corner cases bypass iteration (IDLE→DONE, latency 1):
  - divisor 0: quotient all ones; remainder = dividend.
  - signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder 0.
- mulh returns the upper XLEN bits of the signed×signed product, mulhsu signed×unsigned, mulhu unsigned×unsigned; mul returns the lower XLEN bits.
- inValid while not ready is ignored; the producer must hold its inputs.

Decomposition:
- Package alu_md_pkg holds:
  - localparams for the 16 op codes and the aluOp encodings;
  - the FSM state encoding;
  - opcode constants OP_R=7'b0110011 and OP_I=7'b0010011;
  - funct7 constant M_EXT=7'b0000001.
- One sub-module, md_iter_core (parameter XLEN): start/done handshake, mode input mul/div, signed flags, hi/lo outputs. It contains the shift-add and restoring-divide iteration counter. The top level owns decode, the single-cycle datapath, corner-case bypass and the handshake FSM.

Test Plan:
1. Reset, then R-type aluOp=01 funct7=0100000 funct3=000, A=10, B=3 → outValid 1 cycle after accept, result=7, aluControl=0001; srai funct3=101 A=0x80000000 B=4 → 0xF8000000.
2. mul A=−3 B=7 → result=0xFFFFFFEB exactly XLEN+1=33 cycles after accept; mulhu A=B=0xFFFFFFFF → 0xFFFFFFFE; inReady=0 throughout.
3. div A=7 B=0 → 0xFFFFFFFF, rem → 7, both latency 1; div A=0x80000000 B=0xFFFFFFFF → 0x80000000, rem → 0.
4. Hold outReady=0 for 5 cycles after a result → outValid, result and inReady=0 stable; second inValid ignored until handshake completes.
5. Branch aluOp=10 funct3=110 A=1 B=0xFFFFFFFF → result=1; funct3=101 same operands → result=1; assert reset mid-DIV → outValid=0, IDLE next cycle, no spurious result.
6. XLEN=16 build, divu A=0xFFFF B=3 → 0x5555 after 17 cycles; ENABLE_M=0 with funct7=0000001 funct3=000 → add result.
